// File: rtl/rom_download_router.sv
`default_nettype none
// ============================================================================
//  Module      : rom_download_router
//  Description : Bridge between the HPS ioctl download stream and the core's
//                dn_* ROM-load port. It filters, registers and bounds-checks
//                ROM bytes, counts accepted bytes, and sequences the core
//                reset as IDLE -> LOAD -> SETTLE -> RUN.
//  Optional    : define ROMLOAD_CHECKSUM_EN to build the running byte-sum
//                checksum. When it is undefined, o_checksum is tied to zero.
//  Ports       :
//    i_clk_sys          system clock, rising edge
//    i_reset            synchronous active-high reset
//    i_ioctl_download   HPS download in progress
//    i_ioctl_wr         one-cycle byte strobe from HPS
//    i_ioctl_addr[24:0] byte address of i_ioctl_dout
//    i_ioctl_dout[7:0]  download byte
//    o_dn_addr          registered ROM write address
//    o_dn_data          registered ROM write data
//    o_dn_wr            one-cycle ROM write strobe
//    o_game_reset       core reset, active-high
//    o_load_done        high while the core runs with a completed image
//    o_byte_count[16:0] accepted writes in the current/last download
//    o_overflow         sticky out-of-range write flag for this download
//    o_checksum[15:0]   running byte sum of accepted writes
//  Revision    : 1.0  initial release
// ============================================================================
module rom_download_router #(
    parameter int ADDR_W      = 16,
    parameter int ROM_SIZE    = 65536,
    parameter int HOLD_CYCLES = 16
) (
    input  logic              i_clk_sys,
    input  logic              i_reset,
    input  logic              i_ioctl_download,
    input  logic              i_ioctl_wr,
    input  logic [24:0]       i_ioctl_addr,
    input  logic [7:0]        i_ioctl_dout,
    output logic [ADDR_W-1:0] o_dn_addr,
    output logic [7:0]        o_dn_data,
    output logic              o_dn_wr,
    output logic              o_game_reset,
    output logic              o_load_done,
    output logic [16:0]       o_byte_count,
    output logic              o_overflow,
    output logic [15:0]       o_checksum
);

    localparam int              c_HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_INIT = c_HOLD_W'(HOLD_CYCLES - 1);
    // One bit wider than the ioctl address so ROM_SIZE itself is representable.
    localparam logic [25:0]     c_ROM_LIMIT = 26'(ROM_SIZE);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_SETTLE = 2'd2,
        S_RUN    = 2'd3
    } state_t;

    state_t              r_state;
    logic [c_HOLD_W-1:0] r_hold;
    logic [ADDR_W-1:0]   r_dn_addr;
    logic [7:0]          r_dn_data;
    logic                r_dn_wr;
    logic                r_game_reset;
    logic                r_load_done;
    logic [16:0]         r_byte_count;
    logic                r_overflow;

    logic w_in_range;
    logic w_strobe;
    logic w_enter_load;

    assign w_in_range   = ({1'b0, i_ioctl_addr} < c_ROM_LIMIT);
    // A strobe in the cycle download falls is dropped: the FSM is leaving LOAD.
    assign w_strobe     = (r_state == S_LOAD) && i_ioctl_download && i_ioctl_wr;
    assign w_enter_load = (r_state != S_LOAD) && i_ioctl_download;

`ifdef ROMLOAD_CHECKSUM_EN
    logic [15:0] r_checksum;
    assign o_checksum = r_checksum;
`else
    assign o_checksum = 16'h0000;
`endif

    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_hold       <= '0;
            r_dn_addr    <= '0;
            r_dn_data    <= '0;
            r_dn_wr      <= 1'b0;
            r_game_reset <= 1'b1;
            r_load_done  <= 1'b0;
            r_byte_count <= '0;
            r_overflow   <= 1'b0;
`ifdef ROMLOAD_CHECKSUM_EN
            r_checksum   <= '0;
`endif
        end else begin
            r_dn_wr <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (i_ioctl_download) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (!i_ioctl_download) begin
                        r_state <= S_SETTLE;
                        r_hold  <= c_HOLD_INIT;
                    end else if (w_strobe) begin
                        if (w_in_range) begin
                            r_dn_addr <= i_ioctl_addr[ADDR_W-1:0];
                            r_dn_data <= i_ioctl_dout;
                            r_dn_wr   <= 1'b1;
                            if (r_byte_count != '1) begin
                                r_byte_count <= r_byte_count + 17'd1;
                            end
`ifdef ROMLOAD_CHECKSUM_EN
                            r_checksum <= r_checksum + {8'h00, i_ioctl_dout};
`endif
                        end else begin
                            r_overflow <= 1'b1;
                        end
                    end
                end
                S_SETTLE: begin
                    if (i_ioctl_download) begin
                        r_state <= S_LOAD;
                    end else if (r_hold == '0) begin
                        r_state      <= S_RUN;
                        r_game_reset <= 1'b0;
                        r_load_done  <= 1'b1;
                    end else begin
                        r_hold <= r_hold - 1'b1;
                    end
                end
                S_RUN: begin
                    if (i_ioctl_download) begin
                        r_state <= S_LOAD;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // Every way into LOAD starts a fresh image: core held, stats cleared.
            if (w_enter_load) begin
                r_game_reset <= 1'b1;
                r_load_done  <= 1'b0;
                r_byte_count <= '0;
                r_overflow   <= 1'b0;
`ifdef ROMLOAD_CHECKSUM_EN
                r_checksum   <= '0;
`endif
            end
        end
    end

    assign o_dn_addr    = r_dn_addr;
    assign o_dn_data    = r_dn_data;
    assign o_dn_wr      = r_dn_wr;
    assign o_game_reset = r_game_reset;
    assign o_load_done  = r_load_done;
    assign o_byte_count = r_byte_count;
    assign o_overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_rom_download_router.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rom_download_router
//  Description : Directed self-checking bench for rom_download_router with a
//                write scoreboard (expected dn_* writes queued at stimulus,
//                popped when dn_wr is observed).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rom_download_router;

    localparam int c_ADDR_W = 16;
    localparam int c_ROM    = 16;
    localparam int c_HOLD   = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              dl;
    logic              wr;
    logic [24:0]       addr;
    logic [7:0]        dout;
    logic [c_ADDR_W-1:0] dn_addr;
    logic [7:0]        dn_data;
    logic              dn_wr;
    logic              game_reset;
    logic              load_done;
    logic [16:0]       byte_count;
    logic              overflow;
    logic [15:0]       checksum;

    rom_download_router #(
        .ADDR_W      (c_ADDR_W),
        .ROM_SIZE    (c_ROM),
        .HOLD_CYCLES (c_HOLD)
    ) u_dut (
        .i_clk_sys        (clk),
        .i_reset          (rst),
        .i_ioctl_download (dl),
        .i_ioctl_wr       (wr),
        .i_ioctl_addr     (addr),
        .i_ioctl_dout     (dout),
        .o_dn_addr        (dn_addr),
        .o_dn_data        (dn_data),
        .o_dn_wr          (dn_wr),
        .o_game_reset     (game_reset),
        .o_load_done      (load_done),
        .o_byte_count     (byte_count),
        .o_overflow       (overflow),
        .o_checksum       (checksum)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
        logic [31:0] cyc;
    } wr_t;

    wr_t         sb[$];
    logic [31:0] cyc = 0;
    int          n_tests = 0;
    int          n_fails = 0;
    int          exp_cnt = 0;
    logic [15:0] exp_sum = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_ck();
`ifdef ROMLOAD_CHECKSUM_EN
        return exp_sum;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one strobe; queue the expected write if it should be accepted.
    task automatic strobe(input logic [24:0] a, input logic [7:0] d, input bit accept);
        wr   = 1'b1;
        addr = a;
        dout = d;
        if (accept) begin
            sb.push_back('{addr: a[15:0], data: d, cyc: cyc + 1});
            exp_cnt++;
            exp_sum = exp_sum + {8'h00, d};
        end
    endtask

    task automatic clear_model();
        exp_cnt = 0;
        exp_sum = 0;
    endtask

    // Counts post-edge samples with game_reset high, starting at the edge
    // that samples download low.
    task automatic measure_hold(output int n);
        n = 0;
        while (game_reset === 1'b1 && n < 100) begin
            n++;
            tick();
        end
    endtask

    always @(negedge clk) begin
        if (dn_wr === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_dn_wr", 32'd1, 32'd0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("dn_addr", {16'h0, dn_addr}, {16'h0, e.addr});
                check("dn_data", {24'h0, dn_data}, {24'h0, e.data});
                check("dn_wr_latency", cyc, e.cyc);
            end
        end
    end

    initial begin
        int n;
        int t1_bad;
        logic [7:0] t2_data [4];
        t2_data = '{8'h11, 8'h22, 8'h33, 8'h44};

        rst = 1'b1; dl = 1'b0; wr = 1'b0; addr = '0; dout = '0;
        tick();
        tick();
        check("rst_game_reset", {31'h0, game_reset}, 32'd1);
        check("rst_load_done",  {31'h0, load_done},  32'd0);
        check("rst_dn_wr",      {31'h0, dn_wr},      32'd0);
        check("rst_dn_addr",    {16'h0, dn_addr},    32'd0);
        check("rst_dn_data",    {24'h0, dn_data},    32'd0);
        check("rst_byte_count", {15'h0, byte_count}, 32'd0);
        check("rst_overflow",   {31'h0, overflow},   32'd0);
        check("rst_checksum",   {16'h0, checksum},   32'd0);

        // T1: idle without download; random strobes must be ignored.
        rst = 1'b0;
        t1_bad = 0;
        for (int i = 0; i < 100; i++) begin
            wr   = 1'($urandom_range(0, 1));
            addr = 25'($urandom_range(0, 15));
            dout = 8'($urandom);
            tick();
            if (game_reset !== 1'b1 || load_done !== 1'b0) t1_bad++;
        end
        wr = 1'b0;
        check("t1_idle_outputs", t1_bad, 0);
        check("t1_byte_count", {15'h0, byte_count}, 32'd0);

        // T2: download rises with a strobe in the same cycle (ignored), then 4 bytes.
        dl = 1'b1;
        strobe(25'd5, 8'h99, 1'b0);
        tick();
        clear_model();
        check("t2_game_reset", {31'h0, game_reset}, 32'd1);
        check("t2_load_done",  {31'h0, load_done},  32'd0);
        for (int i = 0; i < 4; i++) begin
            strobe(25'(i), t2_data[i], 1'b1);
            tick();
        end
        wr = 1'b0;
        tick();
        check("t2_byte_count", {15'h0, byte_count}, exp_cnt);
        check("t2_checksum",   {16'h0, checksum},   {16'h0, exp_ck()});
        check("t2_overflow",   {31'h0, overflow},   32'd0);

        // T3: last in-range address accepted, ROM_SIZE rejected.
        strobe(25'd15, 8'h5A, 1'b1);
        tick();
        strobe(25'd16, 8'h77, 1'b0);
        tick();
        wr = 1'b0;
        tick();
        check("t3_byte_count", {15'h0, byte_count}, exp_cnt);
        check("t3_overflow",   {31'h0, overflow},   32'd1);
        check("t3_hold_addr",  {16'h0, dn_addr},    32'd15);
        check("t3_hold_data",  {24'h0, dn_data},    32'h5A);
        check("t3_checksum",   {16'h0, checksum},   {16'h0, exp_ck()});

        // T4: download falls with a strobe in the same cycle (ignored).
        dl = 1'b0;
        strobe(25'd7, 8'hEE, 1'b0);
        tick();
        wr = 1'b0;
        measure_hold(n);
        check("t4_hold_cycles", n, c_HOLD);
        check("t4_load_done",   {31'h0, load_done},  32'd1);
        check("t4_count_held",  {15'h0, byte_count}, exp_cnt);
        check("t4_ovf_held",    {31'h0, overflow},   32'd1);
        check("t4_ck_held",     {16'h0, checksum},   {16'h0, exp_ck()});

        // T4b: re-entry to LOAD from SETTLE clears counts and restarts hold.
        dl = 1'b1;
        tick();
        clear_model();
        strobe(25'd1, 8'h10, 1'b1);
        tick();
        strobe(25'd2, 8'h20, 1'b1);
        tick();
        wr = 1'b0;
        dl = 1'b0;
        tick();
        tick();
        tick();
        check("t4b_settle_reset", {31'h0, game_reset}, 32'd1);
        check("t4b_settle_done",  {31'h0, load_done},  32'd0);
        check("t4b_count_before", {15'h0, byte_count}, 32'd2);
        dl = 1'b1;
        tick();
        clear_model();
        check("t4b_count_cleared", {15'h0, byte_count}, 32'd0);
        check("t4b_ck_cleared",    {16'h0, checksum},   32'd0);
        strobe(25'd9, 8'h03, 1'b1);
        tick();
        wr = 1'b0;
        dl = 1'b0;
        tick();
        measure_hold(n);
        check("t4b_hold_cycles", n, c_HOLD);
        check("t4b_load_done",   {31'h0, load_done},  32'd1);
        check("t4b_byte_count",  {15'h0, byte_count}, exp_cnt);
        check("t4b_checksum",    {16'h0, checksum},   {16'h0, exp_ck()});

        // T6: download from RUN; strobe in the rise cycle ignored.
        dl = 1'b1;
        strobe(25'd2, 8'h55, 1'b0);
        tick();
        wr = 1'b0;
        clear_model();
        check("t6_game_reset", {31'h0, game_reset}, 32'd1);
        check("t6_load_done",  {31'h0, load_done},  32'd0);
        check("t6_byte_count", {15'h0, byte_count}, 32'd0);

        // T5: reset mid-LOAD after two writes, second write still on dn_wr.
        strobe(25'd0, 8'hA0, 1'b1);
        tick();
        strobe(25'd1, 8'hB0, 1'b1);
        tick();
        check("t5_count_pre", {15'h0, byte_count}, 32'd2);
        rst = 1'b1;
        strobe(25'd2, 8'hC0, 1'b0);
        tick();
        check("t5_dn_wr",      {31'h0, dn_wr},      32'd0);
        check("t5_byte_count", {15'h0, byte_count}, 32'd0);
        check("t5_game_reset", {31'h0, game_reset}, 32'd1);
        check("t5_load_done",  {31'h0, load_done},  32'd0);
        check("t5_dn_addr",    {16'h0, dn_addr},    32'd0);
        rst = 1'b0;
        dl  = 1'b0;
        wr  = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("t5_idle_reset", {31'h0, game_reset}, 32'd1);
        check("t5_idle_done",  {31'h0, load_done},  32'd0);

        tick();
        check("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
